// File: rtl/fv_bank_cntl_pkg.sv
// Shared types for the FV bank read path: request/beat structs, controller state enum and
// default widths taken from the FV width macros.
`ifndef FV_DATA_W
`define FV_DATA_W 16
`endif
`ifndef FV_ADDR_W
`define FV_ADDR_W 2
`endif
`ifndef FV_TAG_W
`define FV_TAG_W 4
`endif
`ifndef FV_BURST_LEN
`define FV_BURST_LEN 4
`endif

package fv_bank_cntl_pkg;

  localparam int DEF_DATA_W    = `FV_DATA_W;
  localparam int DEF_ADDR_W    = `FV_ADDR_W;
  localparam int DEF_TAG_W     = `FV_TAG_W;
  localparam int DEF_BURST_LEN = `FV_BURST_LEN;

  typedef struct packed {
    logic                  valid;
    logic [DEF_TAG_W-1:0]  pe_tag;
    logic [DEF_ADDR_W-1:0] fv_bank_addr;
  } fv_req_t;

  typedef struct packed {
    logic                  valid;
    logic [DEF_DATA_W-1:0] data;
    logic [DEF_TAG_W-1:0]  pe_tag;
    logic                  last;
  } fv_beat_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } fv_bank_cntl_state_t;

endpackage

// File: rtl/fv_beat_fifo.sv
// Two-entry synchronous FIFO with occupancy count; head is visible combinationally.
// A pop on an empty FIFO is ignored; a push into a full FIFO without a pop is an error.
module fv_beat_fifo #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_pop;

  assign empty  = (count == 2'd0);
  assign do_pop = pop & ~empty;
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
      end
      wr_ptr <= wr_ptr ^ push;
      rd_ptr <= rd_ptr ^ do_pop;
      count  <= count + 2'(push) - 2'(do_pop);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !do_pop && count == 2'd2));

endmodule

// File: rtl/fv_bank_cntl.sv
// Per-bank FV read controller: one request -> BURST_LEN SRAM reads -> BURST_LEN beats to the PE.
// Reads are credit-limited so FIFO entries plus the in-flight read never exceed two.
module fv_bank_cntl
  import fv_bank_cntl_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int TAG_W     = DEF_TAG_W,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 req_valid,
  input  logic [TAG_W-1:0]                     req_pe_tag,
  input  logic [ADDR_W-1:0]                    req_bank_addr,
  output logic                                 bank_busy,
  output logic                                 req_drop,
  output logic                                 mem_ren,
  output logic [ADDR_W+$clog2(BURST_LEN)-1:0]  mem_raddr,
  input  logic [DATA_W-1:0]                    mem_rdata,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [DATA_W-1:0]                    out_data,
  output logic [TAG_W-1:0]                     out_pe_tag,
  output logic                                 out_last
);

  localparam int WIDX_W = $clog2(BURST_LEN);
  localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(BURST_LEN - 1);

  fv_bank_cntl_state_t state, state_nxt;

  logic [TAG_W-1:0]  tag_q;
  logic [ADDR_W-1:0] row_q;
  logic [WIDX_W-1:0] issue_idx;
  logic              inflight;
  logic              inflight_last;
  logic              drop_q;

  logic [1:0]        fifo_count;
  logic              fifo_empty;
  logic [DATA_W:0]   head_ent;
  logic              head_last;
  logic              pop;
  logic [2:0]        occ;
  logic              issue_last;

  assign out_valid  = ~fifo_empty;
  assign pop        = out_valid & out_ready;
  assign head_last  = head_ent[0];
  assign out_data   = head_ent[DATA_W:1];
  assign out_last   = out_valid & head_last;
  assign out_pe_tag = tag_q;
  assign bank_busy  = (state != S_IDLE);
  assign req_drop   = drop_q;

  // Occupancy as it will stand after this cycle's pop; a read is allowed only if it fits.
  assign occ        = 3'(fifo_count) + 3'(inflight) - 3'(pop);
  assign mem_ren    = (state == S_ISSUE) && (occ < 3'd2);
  assign issue_last = mem_ren && (issue_idx == LAST_IDX);
  assign mem_raddr  = {row_q, issue_idx};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req_valid)         state_nxt = S_ISSUE;
      S_ISSUE: if (issue_last)        state_nxt = S_DRAIN;
      S_DRAIN: if (pop && head_last)  state_nxt = S_IDLE;
      default:                        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q         <= '0;
      row_q         <= '0;
      issue_idx     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      if (state == S_IDLE && req_valid) begin
        tag_q     <= req_pe_tag;
        row_q     <= req_bank_addr;
        issue_idx <= '0;
      end else if (mem_ren) begin
        issue_idx <= issue_idx + 1'b1;
      end
      inflight      <= mem_ren;
      inflight_last <= issue_last;
      drop_q        <= req_valid && (state != S_IDLE);
    end
  end

  // Clearing inflight on reset is what makes a read returning after reset harmless.
  fv_beat_fifo #(.W(DATA_W + 1)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight),
    .push_data ({mem_rdata, inflight_last}),
    .pop       (pop),
    .head      (head_ent),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule
